// File: rtl/red_ctrl_front.sv
// ============================================================================
// red_ctrl_front
// ----------------------------------------------------------------------------
// Two-stage fetch/decode front end for the reduced RISC-V execute datapath.
//
//   F stage : the PC register drives instruction memory (instr_addr = PC). The
//             returned word is captured into the instruction register (IR)
//             together with its own PC (pc_d).
//   D stage : IR is decoded combinationally into every control and operand
//             input of the datapath. Branches and jal resolve here, using the
//             datapath's Zero flag for the instruction currently in D. A taken
//             transfer loads the target into PC and marks IR invalid, so the
//             word fetched on the wrong path is dropped. That costs one bubble.
//
// Supported instructions: add sub and or slt, addi andi ori slti, lui, lw, sw,
// beq bne, jal. Anything else that reaches D with a valid IR raises 'illegal'.
// The hardware treats it as a bubble: it issues no writes and does not redirect.
//
// Optional feature (compile-time macro RED_ILLEGAL_HALT_EN):
//   defined   : an illegal instruction in D sets a sticky illegal flag and
//               freezes PC/IR exactly as en = 0 would, until reset.
//   undefined : illegal is high only while the offending word sits in D and
//               the pipeline keeps running.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   en          in   run enable; low freezes PC, IR and pc_d
//   instr_addr  out  fetch address (= PC)
//   instr       in   instruction word, combinational read of instr_addr
//   Zero        in   datapath ALU zero flag for the instruction in D
//   ImmOp       out  sign-extended immediate of the D instruction
//   RegWrite    out  register file write enable
//   ALUctrl     out  000 add, 001 sub, 010 and, 011 or, 101 slt
//   ALUsrc      out  1 selects ImmOp as ALU operand 2
//   rs1/rs2/rd  out  register indices
//   MemWrite    out  data memory write enable
//   ResultSrc   out  00 ALU, 01 memory, 1x PCPlus4
//   PCPlus4     out  PC of the D instruction + 4
//   illegal     out  D holds a valid but unsupported instruction
// ============================================================================
module red_ctrl_front #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDRESS_WIDTH = 5,
    parameter int                    ALUctrl_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] RESET_PC      = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    output logic [DATA_WIDTH-1:0]    instr_addr,
    input  logic [DATA_WIDTH-1:0]    instr,
    input  logic                     Zero,
    output logic [DATA_WIDTH-1:0]    ImmOp,
    output logic                     RegWrite,
    output logic [ALUctrl_WIDTH-1:0] ALUctrl,
    output logic                     ALUsrc,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic                     MemWrite,
    output logic [1:0]               ResultSrc,
    output logic [DATA_WIDTH-1:0]    PCPlus4,
    output logic                     illegal
);

    // RV32I major opcodes used by the supported subset
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operation encodings understood by the execute datapath
    localparam logic [ALUctrl_WIDTH-1:0] ALU_ADD = ALUctrl_WIDTH'(0);
    localparam logic [ALUctrl_WIDTH-1:0] ALU_SUB = ALUctrl_WIDTH'(1);
    localparam logic [ALUctrl_WIDTH-1:0] ALU_AND = ALUctrl_WIDTH'(2);
    localparam logic [ALUctrl_WIDTH-1:0] ALU_OR  = ALUctrl_WIDTH'(3);
    localparam logic [ALUctrl_WIDTH-1:0] ALU_SLT = ALUctrl_WIDTH'(5);

    // ResultSrc encodings
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Pipeline state
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [31:0]           ir;
    logic                  ir_valid;

    // Instruction fields of the word held in D
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    // Immediate candidates, all sign-extended to DATA_WIDTH
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_b;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [DATA_WIDTH-1:0] imm_j;

    // Raw decode results, before gating by IR validity
    logic                     dec_legal;
    logic                     dec_reg_write;
    logic                     dec_mem_write;
    logic                     dec_is_beq;
    logic                     dec_is_bne;
    logic                     dec_is_jal;
    logic                     dec_rs1_zero;
    logic [ALUctrl_WIDTH-1:0] dec_alu;
    logic                     dec_alu_src;
    logic [1:0]               dec_result_src;
    logic [DATA_WIDTH-1:0]    dec_imm;

    // Control derived from the decode
    logic                  illegal_now;
    logic                  active;
    logic                  taken;
    logic                  halt;
    logic                  advance;
    logic [DATA_WIDTH-1:0] target;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    assign imm_i = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
    assign imm_s = {{(DATA_WIDTH-12){ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {{(DATA_WIDTH-31){ir[31]}}, ir[30:12], 12'b0};
    assign imm_j = {{(DATA_WIDTH-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // Instruction decoder. Everything defaults to zero, so the all-zero IR
    // loaded by reset decodes to all-zero operand/control outputs. Any opcode
    // or funct combination outside the supported set leaves dec_legal low.
    always_comb begin
        dec_legal      = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_write  = 1'b0;
        dec_is_beq     = 1'b0;
        dec_is_bne     = 1'b0;
        dec_is_jal     = 1'b0;
        dec_rs1_zero   = 1'b0;
        dec_alu        = ALU_ADD;
        dec_alu_src    = 1'b0;
        dec_result_src = RES_ALU;
        dec_imm        = '0;

        case (opcode)
            OP_REG: begin
                dec_reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  begin dec_legal = 1'b1; dec_alu = ALU_ADD; end
                        3'b111:  begin dec_legal = 1'b1; dec_alu = ALU_AND; end
                        3'b110:  begin dec_legal = 1'b1; dec_alu = ALU_OR;  end
                        3'b010:  begin dec_legal = 1'b1; dec_alu = ALU_SLT; end
                        default: dec_legal = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_alu   = ALU_SUB;
                end
            end

            OP_IMM: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = imm_i;
                case (funct3)
                    3'b000:  begin dec_legal = 1'b1; dec_alu = ALU_ADD; end
                    3'b111:  begin dec_legal = 1'b1; dec_alu = ALU_AND; end
                    3'b110:  begin dec_legal = 1'b1; dec_alu = ALU_OR;  end
                    3'b010:  begin dec_legal = 1'b1; dec_alu = ALU_SLT; end
                    default: dec_legal = 1'b0;
                endcase
            end

            // lui is computed by the ALU as x0 + imm, so rs1 is forced to zero
            // regardless of what the immediate bits happen to hold there.
            OP_LUI: begin
                dec_legal     = 1'b1;
                dec_reg_write = 1'b1;
                dec_rs1_zero  = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = imm_u;
            end

            OP_LOAD: begin
                dec_legal      = (funct3 == 3'b010);
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_result_src = RES_MEM;
                dec_imm        = imm_i;
            end

            OP_STORE: begin
                dec_legal     = (funct3 == 3'b010);
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = imm_s;
            end

            // Branches compare by subtraction; Zero from the datapath decides.
            OP_BRANCH: begin
                dec_legal  = (funct3 == 3'b000) || (funct3 == 3'b001);
                dec_is_beq = (funct3 == 3'b000);
                dec_is_bne = (funct3 == 3'b001);
                dec_alu    = ALU_SUB;
                dec_imm    = imm_b;
            end

            OP_JAL: begin
                dec_legal      = 1'b1;
                dec_is_jal     = 1'b1;
                dec_reg_write  = 1'b1;
                dec_result_src = RES_PC4;
                dec_imm        = imm_j;
            end

            default: dec_legal = 1'b0;
        endcase
    end

    // Only a valid, legal instruction may write state or redirect fetch.
    // Bubbles and illegal words keep the rest of the decode visible but inert.
    assign illegal_now = ir_valid & ~dec_legal;
    assign active      = ir_valid & dec_legal;
    assign taken       = active & ((dec_is_beq & Zero) | (dec_is_bne & ~Zero) | dec_is_jal);
    assign target      = pc_d + dec_imm;

`ifdef RED_ILLEGAL_HALT_EN
    logic illegal_sticky;

    // Sticky illegal flag. Once an illegal word reaches D the front end stays
    // frozen (the illegal word stays in D) until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_sticky <= 1'b0;
        end else if (illegal_now) begin
            illegal_sticky <= 1'b1;
        end
    end

    // The freeze also applies in the cycle the illegal word is first seen, so
    // the following word never overwrites it in IR.
    assign halt    = illegal_sticky | illegal_now;
    assign illegal = illegal_sticky | illegal_now;
`else
    assign halt    = 1'b0;
    assign illegal = illegal_now;
`endif

    assign advance = en & ~halt;

    // PC / IR / pc_d registers. A redirect loads the target into PC and drops
    // the word currently being fetched by clearing ir_valid. IR and pc_d hold
    // their contents, so the decode outputs stay stable during the bubble.
    // A taken branch seen while en is low waits; Zero is evaluated again on
    // the first enabled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            pc_d     <= RESET_PC;
            ir       <= '0;
            ir_valid <= 1'b0;
        end else if (advance) begin
            if (taken) begin
                pc       <= target;
                ir_valid <= 1'b0;
            end else begin
                pc       <= pc + DATA_WIDTH'(4);
                ir       <= instr[31:0];
                pc_d     <= pc;
                ir_valid <= 1'b1;
            end
        end
    end

    assign instr_addr = pc;
    assign PCPlus4    = pc_d + DATA_WIDTH'(4);
    assign ImmOp      = dec_imm;
    assign ALUctrl    = dec_alu;
    assign ALUsrc     = dec_alu_src;
    assign ResultSrc  = dec_result_src;
    assign rs1        = dec_rs1_zero ? '0 : ADDRESS_WIDTH'(ir[19:15]);
    assign rs2        = ADDRESS_WIDTH'(ir[24:20]);
    assign rd         = ADDRESS_WIDTH'(ir[11:7]);
    assign RegWrite   = active & dec_reg_write;
    assign MemWrite   = active & dec_mem_write;

endmodule
